// File: rtl/prog_loader_pkg.sv
// Shared constants and types for the CHIP-8 program loader.
// Holds the load base address, framing byte values, err_code encodings
// and the loader state encoding.
package prog_loader_pkg;

  localparam logic [11:0] PROG_BASE = 12'h200;
  localparam logic [7:0]  SYNC_BYTE = 8'hC8;
  localparam logic [7:0]  ACK_BYTE  = 8'h06;
  localparam logic [7:0]  NAK_BYTE  = 8'h15;

  localparam int MAX_LEN_DEFAULT = 3584;
  localparam int TIMEOUT_DEFAULT = 1000000;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_CHK     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_t;

  typedef enum logic [2:0] {
    ST_HUNT  = 3'd0,
    ST_LEN_H = 3'd1,
    ST_LEN_L = 3'd2,
    ST_DATA  = 3'd3,
    ST_CHK   = 3'd4
  } state_t;

  // A length is usable when it is non-zero and fits between PROG_BASE and 0xFFF.
  function automatic logic len_ok(input logic [11:0] len, input int max_len);
    return (len != 12'd0) && (int'(len) <= max_len);
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Loader-side bundle: UART receive strobe in, program memory write port,
// interpreter run control, status pulses and the optional echo stream.
// master = the loader, slave = the surrounding system (UART, memory, host).
interface prog_loader_if;
  logic [7:0]  rx_i;
  logic        rx_i_v;
  logic        we;
  logic [11:0] waddr;
  logic [7:0]  d;
  logic        run;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [7:0]  tx_o;
  logic        tx_o_v;

  modport master (
    input  rx_i, rx_i_v,
    output we, waddr, d, run, done, err, err_code, tx_o, tx_o_v
  );

  modport slave (
    output rx_i, rx_i_v,
    input  we, waddr, d, run, done, err, err_code, tx_o, tx_o_v
  );
endinterface

// File: rtl/prog_loader_rx_timeout.sv
// Inter-byte idle timer: down-counter reloaded on clear or while disabled,
// terminal count at zero gives a one-cycle expired pulse and reloads.
module rx_timeout #(
  parameter int TERMINAL = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;
  localparam logic [W-1:0] LOAD = W'(TERMINAL - 1);

  logic [W-1:0] cnt;

  // Expiry is decoded from the register so the loader sees it in the same
  // cycle as any coincident strobe and can let the timeout win.
  assign expired = en && (cnt == '0);

  // Count down while enabled; any strobe, idle state or expiry restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= LOAD;
    end else if (clr || !en || expired) begin
      cnt <= LOAD;
    end else begin
      cnt <= cnt - W'(1);
    end
  end
endmodule

// File: rtl/prog_loader.sv
// CHIP-8 program loader: parses SYNC/LEN/payload/CHK frames from the UART
// and writes the payload into program RAM from PROG_BASE upward, holding
// the interpreter (run=0) until a frame passes its checksum.
// Optional macro PROG_LOADER_ECHO_EN: echo accepted bytes plus ACK/NAK on tx_o.
//
// state    | meaning
// ST_HUNT  | waiting for SYNC, other bytes ignored
// ST_LEN_H | expecting length high nibble
// ST_LEN_L | expecting length low byte, length checked here
// ST_DATA  | writing payload bytes to memory
// ST_CHK   | expecting checksum byte
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int MAX_LEN        = MAX_LEN_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input logic            clk,
  input logic            rst_n,
  prog_loader_if.master  bus
);

  state_t      state;
  logic [3:0]  len_h;
  logic [11:0] addr;
  logic [11:0] remaining;
  logic [7:0]  chk;
  logic        expired;
  logic [11:0] len_rx;

  logic        we_q;
  logic [11:0] waddr_q;
  logic [7:0]  d_q;
  logic        run_q;
  logic        done_q;
  logic        err_q;
  err_code_t   err_code_q;

  assign len_rx = {len_h, bus.rx_i};

  rx_timeout #(.TERMINAL(TIMEOUT_CYCLES)) u_rx_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (bus.rx_i_v),
    .en      (state != ST_HUNT),
    .expired (expired)
  );

  // Frame parser with registered memory-port and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_HUNT;
      len_h      <= '0;
      addr       <= PROG_BASE;
      remaining  <= '0;
      chk        <= '0;
      we_q       <= 1'b0;
      waddr_q    <= PROG_BASE;
      d_q        <= '0;
      run_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (expired) begin
        // A strobe in this same cycle is deliberately dropped.
        err_q      <= 1'b1;
        err_code_q <= ERR_TIMEOUT;
        state      <= ST_HUNT;
      end else if (bus.rx_i_v) begin
        unique case (state)
          ST_HUNT: begin
            if (bus.rx_i == SYNC_BYTE) begin
              run_q <= 1'b0;
              state <= ST_LEN_H;
            end
          end
          ST_LEN_H: begin
            len_h <= bus.rx_i[3:0];
            state <= ST_LEN_L;
          end
          ST_LEN_L: begin
            if (len_ok(len_rx, MAX_LEN)) begin
              chk       <= '0;
              addr      <= PROG_BASE;
              remaining <= len_rx;
              state     <= ST_DATA;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= ERR_LEN;
              state      <= ST_HUNT;
            end
          end
          ST_DATA: begin
            we_q      <= 1'b1;
            waddr_q   <= addr;
            d_q       <= bus.rx_i;
            addr      <= addr + 12'd1;
            chk       <= chk + bus.rx_i;
            remaining <= remaining - 12'd1;
            if (remaining == 12'd1) state <= ST_CHK;
          end
          ST_CHK: begin
            if (bus.rx_i == chk) begin
              done_q     <= 1'b1;
              run_q      <= 1'b1;
              err_code_q <= ERR_NONE;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= ERR_CHK;
            end
            state <= ST_HUNT;
          end
          default: state <= ST_HUNT;
        endcase
      end
    end
  end

  assign bus.we       = we_q;
  assign bus.waddr    = waddr_q;
  assign bus.d        = d_q;
  assign bus.run      = run_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.err_code = err_code_q;

`ifdef PROG_LOADER_ECHO_EN
  logic       accepted;
  logic       frame_end;
  logic [7:0] tx_q;
  logic       tx_v_q;
  logic       pend;
  logic [7:0] pend_byte;

  assign accepted  = bus.rx_i_v && !expired &&
                     ((state != ST_HUNT) || (bus.rx_i == SYNC_BYTE));
  assign frame_end = (state == ST_CHK) ||
                     ((state == ST_LEN_L) && !len_ok(len_rx, MAX_LEN));

  // Echo each accepted byte; the closing ACK/NAK follows one cycle after the
  // last echoed byte. If a new SYNC lands in that slot its echo is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q      <= '0;
      tx_v_q    <= 1'b0;
      pend      <= 1'b0;
      pend_byte <= '0;
    end else begin
      tx_v_q <= 1'b0;
      pend   <= 1'b0;
      if (expired) begin
        tx_q   <= NAK_BYTE;
        tx_v_q <= 1'b1;
      end else if (pend) begin
        tx_q   <= pend_byte;
        tx_v_q <= 1'b1;
      end else if (accepted) begin
        tx_q   <= bus.rx_i;
        tx_v_q <= 1'b1;
      end
      if (accepted && frame_end) begin
        pend      <= 1'b1;
        pend_byte <= ((state == ST_CHK) && (bus.rx_i == chk)) ? ACK_BYTE : NAK_BYTE;
      end
    end
  end

  assign bus.tx_o   = tx_q;
  assign bus.tx_o_v = tx_v_q;
`else
  assign bus.tx_o   = '0;
  assign bus.tx_o_v = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (short timeout for simulation).
module tb_prog_loader;
  localparam int TO = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prog_loader_if bus();

  prog_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int we_cnt = 0, done_cnt = 0, err_cnt = 0, tx_cnt = 0;
  logic [7:0]  mem [0:4095];
  logic [11:0] last_waddr = '0;
  logic [7:0]  last_d = '0;
  logic [7:0]  tx_q [$];

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.we) begin
        mem[bus.waddr] = bus.d;
        last_waddr = bus.waddr;
        last_d = bus.d;
        we_cnt++;
      end
      if (bus.done) done_cnt++;
      if (bus.err) err_cnt++;
      if (bus.tx_o_v) begin
        tx_q.push_back(bus.tx_o);
        tx_cnt++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    bus.rx_i = b;
    bus.rx_i_v = 1'b1;
    @(negedge clk);
    bus.rx_i_v = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_counts();
    we_cnt = 0; done_cnt = 0; err_cnt = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    bus.rx_i = '0;
    bus.rx_i_v = 1'b0;
    rst_n = 1'b0;
    idle(3);
    check("rst_we", bus.we, 1'b0);
    check("rst_waddr", bus.waddr, 12'h200);
    check("rst_d", bus.d, 8'h00);
    check("rst_run", bus.run, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_err", bus.err, 1'b0);
    check("rst_err_code", bus.err_code, 2'd0);
    check("rst_tx_o", bus.tx_o, 8'h00);
    check("rst_tx_o_v", bus.tx_o_v, 1'b0);
    rst_n = 1'b1;
    idle(2);

    // Good frame, back-to-back bytes
    send(8'hC8, 0); send(8'h00, 0); send(8'h03, 0);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h66, 0);
    idle(4);
    check("f1_we_cnt", we_cnt, 3);
    check("f1_m200", mem[12'h200], 8'h11);
    check("f1_m201", mem[12'h201], 8'h22);
    check("f1_m202", mem[12'h202], 8'h33);
    check("f1_done", done_cnt, 1);
    check("f1_err", err_cnt, 0);
    check("f1_run", bus.run, 1'b1);
    check("f1_err_code", bus.err_code, 2'd0);

    // New SYNC drops run; then bad checksum
    clear_counts();
    send(8'hC8, 0);
    check("sync_run_drop", bus.run, 1'b0);
    send(8'h00, 1); send(8'h02, 1); send(8'hAA, 1); send(8'hBB, 1); send(8'h00, 1);
    idle(4);
    check("f2_we_cnt", we_cnt, 2);
    check("f2_m200", mem[12'h200], 8'hAA);
    check("f2_m201", mem[12'h201], 8'hBB);
    check("f2_err", err_cnt, 1);
    check("f2_done", done_cnt, 0);
    check("f2_err_code", bus.err_code, 2'd2);
    check("f2_run", bus.run, 1'b0);

    // Zero length
    clear_counts();
    send(8'hC8, 1); send(8'h00, 1); send(8'h00, 1);
    idle(2);
    check("len0_err", err_cnt, 1);
    check("len0_err_code", bus.err_code, 2'd1);

    // Length 3585, trailing bytes ignored until next SYNC
    clear_counts();
    send(8'hC8, 1); send(8'h0E, 1); send(8'h01, 1);
    idle(2);
    check("len_big_err", err_cnt, 1);
    check("len_big_err_code", bus.err_code, 2'd1);
    check("len_big_we", we_cnt, 0);
    send(8'h00, 1); send(8'h03, 1); send(8'h11, 1); send(8'h22, 1); send(8'h33, 1);
    idle(3);
    check("ignored_we", we_cnt, 0);
    check("ignored_err", err_cnt, 1);
    check("ignored_done", done_cnt, 0);

    // Timeout mid-payload
    clear_counts();
    send(8'hC8, 1); send(8'h00, 1); send(8'h04, 1); send(8'h01, 1); send(8'h02, 1);
    waited = 0;
    while (waited < 200 && err_cnt == 0) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("to_fired", err_cnt, 1);
    check("to_err_code", bus.err_code, 2'd3);
    check("to_we_cnt", we_cnt, 2);
    check("to_run", bus.run, 1'b0);
    check("to_latency_ok", (waited >= TO - 3) && (waited <= TO + 1), 1'b1);
    idle(3);

    // Fresh frame after timeout; also the echo frame
    clear_counts();
    tx_q.delete();
    send(8'hC8, 0); send(8'h00, 0); send(8'h01, 0); send(8'h7F, 0); send(8'h7F, 0);
    idle(4);
    check("f3_done", done_cnt, 1);
    check("f3_err", err_cnt, 0);
    check("f3_m200", mem[12'h200], 8'h7F);
    check("f3_run", bus.run, 1'b1);
`ifdef PROG_LOADER_ECHO_EN
    begin
      logic [7:0] exp_tx [6];
      exp_tx = '{8'hC8, 8'h00, 8'h01, 8'h7F, 8'h7F, 8'h06};
      check("echo_len", tx_q.size(), 6);
      for (int i = 0; i < 6; i++) begin
        if (i < tx_q.size()) check($sformatf("echo_%0d", i), tx_q[i], exp_tx[i]);
        else check($sformatf("echo_%0d_missing", i), 1'b0, 1'b1);
      end
    end
`else
    check("no_echo_cnt", tx_cnt, 0);
    check("no_echo_tx_o", bus.tx_o, 8'h00);
`endif

    // Maximum length 3584, payload i mod 256, checksum 0x00
    clear_counts();
    send(8'hC8, 0); send(8'h0E, 0); send(8'h00, 0);
    for (int i = 0; i < 3584; i++) send(8'(i), 0);
    send(8'h00, 0);
    idle(4);
    check("max_we_cnt", we_cnt, 3584);
    check("max_last_waddr", last_waddr, 12'hFFF);
    check("max_last_d", last_d, 8'hFF);
    check("max_m200", mem[12'h200], 8'h00);
    check("max_m300", mem[12'h300], 8'h00);
    check("max_m2ff", mem[12'h2FF], 8'hFF);
    check("max_done", done_cnt, 1);
    check("max_err", err_cnt, 0);
    check("max_run", bus.run, 1'b1);

    // Asynchronous reset in the middle of the payload
    clear_counts();
    send(8'hC8, 0); send(8'h00, 0); send(8'h05, 0); send(8'h01, 0); send(8'h02, 0);
    check("pre_rst_we", bus.we, 1'b1);
    check("pre_rst_waddr", bus.waddr, 12'h201);
    check("pre_rst_d", bus.d, 8'h02);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_we", bus.we, 1'b0);
    check("arst_waddr", bus.waddr, 12'h200);
    check("arst_d", bus.d, 8'h00);
    check("arst_run", bus.run, 1'b0);
    check("arst_done", bus.done, 1'b0);
    check("arst_err", bus.err, 1'b0);
    check("arst_err_code", bus.err_code, 2'd0);
    check("arst_tx_o_v", bus.tx_o_v, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
